// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO with ready/valid input feeding a frame
// serialiser with configurable data width, parity and stop bits.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int DATA_BITS   = 8,
  parameter int FIFO_AW     = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 overflow
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam int BW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int IW    = $clog2(DATA_BITS);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wptr;
  logic [FIFO_AW-1:0]   r_rptr;
  logic [FIFO_AW:0]     r_count;
  logic                 r_ovf;

  logic [2:0]           r_state;
  logic [BW-1:0]        r_baud;
  logic [IW-1:0]        r_bit;
  logic                 r_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_txd;
  logic                 r_busy;

  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic [DATA_BITS-1:0] w_head;

  // count never exceeds DEPTH, so its MSB alone flags a full FIFO
  assign w_ready   = ~r_count[FIFO_AW];
  assign w_push    = tx_valid & w_ready;
  assign w_bit_end = (r_baud == BAUD_LAST);
  assign w_head    = r_mem[r_rptr];
  assign w_pop     = (r_count != '0) &&
                     ((r_state == S_IDLE) ||
                      ((r_state == S_STOP) && w_bit_end && (r_stop == STOP_LAST)));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (tx_valid && !w_ready) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      if (r_state != S_IDLE) r_baud <= w_bit_end ? '0 : r_baud + BW'(1);
      // Pop takes priority so the last stop bit flows straight into a start bit
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= ^w_head;
        r_txd   <= 1'b0;
        r_busy  <= 1'b1;
        r_baud  <= '0;
        r_state <= S_START;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_txd  <= 1'b1;
            r_busy <= 1'b0;
          end
          S_START: if (w_bit_end) begin
            r_txd   <= r_shift[0];
            r_bit   <= '0;
            r_state <= S_DATA;
          end
          S_DATA: if (w_bit_end) begin
            if (r_bit == BIT_LAST) begin
              if (PARITY != 0) begin
                r_txd   <= (PARITY == 1) ? r_par : ~r_par;
                r_state <= S_PARITY;
              end else begin
                r_txd   <= 1'b1;
                r_stop  <= 1'b0;
                r_state <= S_STOP;
              end
            end else begin
              r_shift <= r_shift >> 1;
              r_txd   <= r_shift[1];
              r_bit   <= r_bit + IW'(1);
            end
          end
          S_PARITY: if (w_bit_end) begin
            r_txd   <= 1'b1;
            r_stop  <= 1'b0;
            r_state <= S_STOP;
          end
          S_STOP: if (w_bit_end) begin
            if (r_stop == STOP_LAST) begin
              r_txd   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_stop <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_ready   = w_ready;
  assign txd        = r_txd;
  assign busy       = r_busy;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three frame formats driven by shared random and
// directed stimulus, each compared cycle by cycle against a frame-level model.
module tb_uart_tx_fifo;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int CPB [3] = '{4, 4, 3};
  localparam int DB  [3] = '{8, 7, 8};
  localparam int PR  [3] = '{0, 2, 1};
  localparam int SB  [3] = '{1, 2, 1};

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       vld  = 1'b0;
  logic [7:0] din  = '0;

  logic       txd [3];
  logic       busy[3];
  logic       rdy [3];
  logic       ovf [3];
  logic [AW:0] cnt[3];

  int mq [3][DEPTH];
  int mh [3];
  int mn [3];
  int mt [3];
  bit movf[3];
  int fb [3][12];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(8), .FIFO_AW(2), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rstn(rstn), .tx_data(din), .tx_valid(vld), .tx_ready(rdy[0]),
    .txd(txd[0]), .busy(busy[0]), .fifo_count(cnt[0]), .overflow(ovf[0]));

  uart_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(7), .FIFO_AW(2), .PARITY(2), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rstn(rstn), .tx_data(din[6:0]), .tx_valid(vld), .tx_ready(rdy[1]),
    .txd(txd[1]), .busy(busy[1]), .fifo_count(cnt[1]), .overflow(ovf[1]));

  uart_tx_fifo #(.CLK_PER_BIT(3), .DATA_BITS(8), .FIFO_AW(2), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rstn(rstn), .tx_data(din), .tx_valid(vld), .tx_ready(rdy[2]),
    .txd(txd[2]), .busy(busy[2]), .fifo_count(cnt[2]), .overflow(ovf[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int flen(input int k);
    return (1 + DB[k] + ((PR[k] != 0) ? 1 : 0) + SB[k]) * CPB[k];
  endfunction

  // Line levels of one whole frame, one entry per bit period
  task automatic build(input int k, input int w);
    int idx;
    int p;
    p = 0;
    fb[k][0] = 0;
    for (int i = 0; i < DB[k]; i++) begin
      fb[k][1 + i] = (w >> i) & 1;
      p ^= (w >> i) & 1;
    end
    idx = 1 + DB[k];
    if (PR[k] != 0) begin
      fb[k][idx] = (PR[k] == 1) ? p : 1 - p;
      idx++;
    end
    for (int s = 0; s < SB[k]; s++) fb[k][idx + s] = 1;
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (!rstn) begin
        mh[k] = 0; mn[k] = 0; mt[k] = -1; movf[k] = 1'b0;
      end else begin
        int n0;
        int tail;
        bit ready;
        n0    = mn[k];
        ready = (n0 != DEPTH);
        tail  = (mh[k] + n0) % DEPTH;
        if (mt[k] < 0 || mt[k] == flen(k) - 1) begin
          if (n0 != 0) begin
            build(k, mq[k][mh[k]]);
            mh[k] = (mh[k] + 1) % DEPTH;
            mn[k]--;
            mt[k] = 0;
          end else begin
            mt[k] = -1;
          end
        end else begin
          mt[k]++;
        end
        if (vld) begin
          if (ready) begin
            mq[k][tail] = int'(din) & ((1 << DB[k]) - 1);
            mn[k]++;
          end else begin
            movf[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("txd[%0d]", k),   32'(txd[k]),  (mt[k] < 0) ? 32'd1 : 32'(fb[k][mt[k] / CPB[k]]));
      chk($sformatf("busy[%0d]", k),  32'(busy[k]), 32'(mt[k] >= 0));
      chk($sformatf("count[%0d]", k), 32'(cnt[k]),  32'(mn[k]));
      chk($sformatf("ready[%0d]", k), 32'(rdy[k]),  32'(mn[k] != DEPTH));
      chk($sformatf("ovf[%0d]", k),   32'(ovf[k]),  32'(movf[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic push_seq(input logic [7:0] d);
    vld = 1'b1;
    din = d;
    tick();
    vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mh[k] = 0; mn[k] = 0; mt[k] = -1; movf[k] = 1'b0;
    end
    idle(3);
    rstn = 1'b1;
    idle(2);

    push_seq(8'h55);
    idle(60);

    push_seq(8'hA3);
    push_seq(8'h0F);
    push_seq(8'hFF);
    idle(160);

    for (int i = 0; i < 6; i++) push_seq(8'(8'h31 + i));
    idle(300);

    push_seq(8'h07);
    push_seq(8'h00);
    idle(120);

    push_seq(8'hC5);
    push_seq(8'h3A);
    push_seq(8'h99);
    for (int i = 0; i < 200 && mt[0] != 4 * CPB[0] + 1; i++) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    idle(60);

    for (int i = 0; i < 1500; i++) begin
      rstn = ($urandom_range(0, 399) != 0);
      vld  = ((i / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
      din  = 8'($urandom);
      tick();
    end
    rstn = 1'b1;
    vld  = 1'b0;

    for (int i = 0; i < 400; i++) begin
      if (mt[0] < 0 && mt[1] < 0 && mt[2] < 0 && mn[0] == 0 && mn[1] == 0 && mn[2] == 0) break;
      tick();
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal FIFO, ready/valid input handshake, and configurable frame format (data width, parity, stop bits).
Generalises the existing fixed 8N1 buffered transmitter: adds backpressure, overflow reporting, exact bit timing per frame, parity, and back-to-back frames without idle gaps.
Sits between the core's output path and the board TX pin.

Parameters:
CLK_PER_BIT, 868, clock cycles per UART bit; legal range ≥2.
DATA_BITS, 8, data bits per frame; legal range 5..9.
FIFO_AW, 8, FIFO address width; depth = 2**FIFO_AW entries.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2.

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
tx_data  in  DATA_BITS  word to send; LSB is sent first
tx_valid  in  1  tx_data is valid this cycle
tx_ready  out  1  FIFO can accept a word; equals (count != 2**FIFO_AW); no combinational dependence on tx_valid
txd  out  1  serial output, registered
busy  out  1  high while a frame is on the line
fifo_count  out  FIFO_AW+1  number of words stored in the FIFO
overflow  out  1  sticky; set when tx_valid is asserted while tx_ready is low

Behaviour:
- Reset (rstn low at posedge):
  - txd=1, busy=0, overflow=0, fifo_count=0.
  - Read/write pointers = 0; FSM = IDLE; baud counter = 0.
  - Applies mid-frame as well: the frame is aborted, the line returns high on that edge, and FIFO contents are discarded.
- Push:
  - A word is accepted at a posedge where tx_valid && tx_ready.
  - It is written at the write pointer; the write pointer increments with natural wrap at 2**FIFO_AW.
- Dropped write:
  - tx_valid && !tx_ready means no write, and overflow is set to 1.
  - overflow stays 1 until reset.
- Pop:
  - Occurs when the FSM starts a frame: the head word is loaded into the shift register and the read pointer increments, wrapping.
- Simultaneous push and pop: both take effect and fifo_count is unchanged.
- fifo_count: +1 on push only, −1 on pop only. It never exceeds 2**FIFO_AW and never underflows; the FSM never pops when the FIFO is empty.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1, busy=0. If fifo_count≠0, pop, txd←0, busy←1, baud counter←0, go to START.
  - Each non-IDLE state holds its txd value for exactly CLK_PER_BIT cycles. The baud counter counts 0..CLK_PER_BIT−1 and runs only outside IDLE. The state advances when the counter equals CLK_PER_BIT−1.
  - START → DATA: txd←shift[0]; bit index←0.
  - DATA: on each bit end, shift right and send the next bit. After bit DATA_BITS−1, go to PARITY if PARITY≠0, else to STOP.
  - PARITY: txd = XOR of the data bits (even), or its inverse (odd).
  - STOP: txd=1 for STOP_BITS×CLK_PER_BIT cycles.
  - At the end of the last stop bit: if fifo_count≠0, pop and enter START on the same edge (txd←0, no idle cycle). Otherwise go to IDLE with busy←0.
- Latency: a word accepted at posedge E into an empty FIFO with the FSM in IDLE drives txd low after posedge E+1.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_PER_BIT cycles. For example, 8N1 at 868 gives 8680 cycles.
- A push during a frame never disturbs the frame in flight; the shift register holds a private copy of the word.
- Pointer wrap: after 2**FIFO_AW pushes and pops, ordering is preserved (strict FIFO).

Test Plan:
1. CLK_PER_BIT=4, 8N1: push 0x55 once → txd low after the next edge, then pattern 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles; 40 cycles total; busy high for exactly 40 cycles; fifo_count goes 1→0 at frame start.
2. Push 0xA3, 0x0F, 0xFF on consecutive cycles → three frames with no idle cycle between the stop bit and the next start bit; received bytes are A3, 0F, FF in that order.
3. FIFO_AW=2: push 6 words while the first frame is in progress → tx_ready=0 once fifo_count=4; extra writes are dropped and overflow=1; exactly 5 words appear on the line (1 in flight + 4 stored).
4. PARITY=1 then PARITY=2, DATA_BITS=7: send 0x07 → parity bit 1 (even) and 0 (odd); frame is 10 bits.
5. STOP_BITS=2: send 0x00 → line high for 2×CLK_PER_BIT cycles before the next start bit when a back-to-back word is queued.
6. Assert rstn=0 in the middle of data bit 3 with 2 words queued → txd=1, busy=0, fifo_count=0, overflow=0 on that edge; no further frame after rstn rises until a new push.
